// File: rtl/regfile_arbiter_if.sv
// Requester-side bundle for one register-file access port.
// A requester (master) presents a request with read/write addresses and
// write data and sees back its grant, a read-valid tag and the shared read
// data. The arbiter (slave) is the other end.
//   req    : access request, level-held until gnt
//   we     : write enable, meaningful only with req
//   rs, rt : read addresses
//   rd     : write address
//   wdata  : write data
//   gnt    : granted this cycle (combinational)
//   rvalid : rsdata/rtdata belong to this requester's previous-cycle grant
//   rsdata, rtdata : shared read data from the register file
interface regfile_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rsdata;
    logic [DW-1:0] rtdata;

    modport master (
        output req, we, rs, rt, rd, wdata,
        input  gnt, rvalid, rsdata, rtdata
    );

    modport slave (
        input  req, we, rs, rt, rd, wdata,
        output gnt, rvalid, rsdata, rtdata
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Arbiter in front of the 64x32 register file's single access port set.
// Port 0 (CPU pipeline) has priority; port 1 (debug/loader) is protected by
// a starvation counter and may lock the port for up to LOCK_MAX cycles.
// Read data from the register file arrives one cycle after the grant and is
// tagged back to the requester with rvalid.
// Ports:
//   clock, reset_n    : clock and asynchronous active-low reset
//   p0, p1            : requester bundles (regfile_arbiter_if.slave)
//   lock1             : port 1 asks for back-to-back ownership
//   rf_write, rf_rs, rf_rt, rf_rd, rf_wdata : register file access port
//   rf_rsdata, rf_rtdata                    : register file registered reads
module regfile_arbiter #(
    parameter int AW           = 6,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    regfile_arbiter_if.slave p0,
    regfile_arbiter_if.slave p1,
    input  logic          lock1,
    output logic          rf_write,
    output logic [AW-1:0] rf_rs,
    output logic [AW-1:0] rf_rt,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rsdata,
    input  logic [DW-1:0] rf_rtdata
);
    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] LOCK1 = 1'b1;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);

    logic [0:0]    state;
    logic [SW-1:0] starve_cnt;
    logic [LW-1:0] lock_cnt;
    logic          lock_block;
    logic          vld0_p1;
    logic          vld1_p1;

    logic          lock_hold;
    logic          starve_hit;
    logic          arb0;
    logic          arb1;
    logic          gnt0;
    logic          gnt1;

    function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] c);
        if (c == SW'(STARVE_LIMIT))
            return c;
        return c + SW'(1);
    endfunction

    // A lock only holds while port 1 keeps both req1 and lock1 up; as soon
    // as either drops, the normal arbitration runs in that same cycle so
    // port 0 is not made to wait a cycle for the lock to unwind.
    assign lock_hold  = (state == LOCK1) && p1.req && lock1;
    // The cycle after a LOCK_MAX exit belongs to port 0, so starvation
    // cannot immediately hand the port back to port 1.
    assign starve_hit = p1.req && (starve_cnt == SW'(STARVE_LIMIT)) && !lock_block;

    always_comb begin
        arb0 = 1'b0;
        arb1 = 1'b0;
        if (lock_hold)
            arb1 = 1'b1;
        else if (starve_hit)
            arb1 = 1'b1;
        else if (p0.req)
            arb0 = 1'b1;
        else if (p1.req)
            arb1 = 1'b1;
    end

    // Grants are gated by reset so nothing reaches the register file while
    // reset_n is low, even though the arbitration logic is combinational.
    assign gnt0 = arb0 & reset_n;
    assign gnt1 = arb1 & reset_n;

    assign p0.gnt = gnt0;
    assign p1.gnt = gnt1;

    // With no grant the access fields default to port 0.
    assign rf_rs    = gnt1 ? p1.rs    : p0.rs;
    assign rf_rt    = gnt1 ? p1.rt    : p0.rt;
    assign rf_rd    = gnt1 ? p1.rd    : p0.rd;
    assign rf_wdata = gnt1 ? p1.wdata : p0.wdata;
    assign rf_write = (gnt0 & p0.we) | (gnt1 & p1.we);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            lock_block <= 1'b0;
            vld0_p1    <= 1'b0;
            vld1_p1    <= 1'b0;
        end else begin
            vld0_p1 <= gnt0;
            vld1_p1 <= gnt1;

            starve_cnt <= (!p1.req || gnt1) ? '0 : starve_inc(starve_cnt);

            lock_block <= 1'b0;
            if (lock_hold) begin
                // lock_cnt counts grants already taken in this run, so the
                // grant that brings it to LOCK_MAX is the last one.
                if (lock_cnt + LW'(1) == LW'(LOCK_MAX)) begin
                    state      <= ARB;
                    lock_cnt   <= '0;
                    lock_block <= 1'b1;
                end else begin
                    lock_cnt <= lock_cnt + LW'(1);
                end
            end else if (gnt1 && lock1 && !lock_block) begin
                state    <= LOCK1;
                lock_cnt <= LW'(1);
            end else begin
                state    <= ARB;
                lock_cnt <= '0;
            end
        end
    end

    // ---- stage p1: register file read data and its owner tag ----
    assign p0.rvalid = vld0_p1;
    assign p1.rvalid = vld1_p1;
    assign p0.rsdata = rf_rsdata;
    assign p0.rtdata = rf_rtdata;
    assign p1.rsdata = rf_rsdata;
    assign p1.rtdata = rf_rtdata;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed vectors, a behavioural arbitration and
// register-file model compared every cycle, and hand-computed literal checks.
module tb_regfile_arbiter;
    localparam int AW           = 6;
    localparam int DW           = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int LOCK_MAX     = 8;

    logic          clock;
    logic          reset_n;
    logic          lock1;
    logic          rf_write;
    logic [AW-1:0] rf_rs, rf_rt, rf_rd;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rsdata, rf_rtdata;

    regfile_arbiter_if #(.AW(AW), .DW(DW)) p0_if ();
    regfile_arbiter_if #(.AW(AW), .DW(DW)) p1_if ();

    regfile_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .p0(p0_if),
        .p1(p1_if),
        .lock1(lock1),
        .rf_write(rf_write),
        .rf_rs(rf_rs),
        .rf_rt(rf_rt),
        .rf_rd(rf_rd),
        .rf_wdata(rf_wdata),
        .rf_rsdata(rf_rsdata),
        .rf_rtdata(rf_rtdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file environment: registered reads, read-before-write.
    logic [DW-1:0] mem [64];
    always @(posedge clock) begin
        rf_rsdata <= mem[rf_rs];
        rf_rtdata <= mem[rf_rt];
        if (rf_write)
            mem[rf_rd] <= rf_wdata;
    end

    // Behavioural model: architectural register contents plus the
    // arbitration history that the rules depend on.
    logic [DW-1:0] arch [64];
    int            denied;   // consecutive cycles port 1 has waited
    int            run;      // grants taken in the current lock run
    bit            blocked;  // cycle right after a full-length lock
    bit            pv0, pv1;
    logic [DW-1:0] prs, prt;
    bit            e0, e1, ew, nb;
    logic [AW-1:0] srs, srt, srd;
    logic [DW-1:0] swd;

    always @(negedge clock) begin
        if (!reset_n) begin
            denied  = 0;
            run     = 0;
            blocked = 0;
            pv0     = 0;
            pv1     = 0;
            check("reset_gnt0", {31'b0, p0_if.gnt}, 0);
            check("reset_gnt1", {31'b0, p1_if.gnt}, 0);
            check("reset_rf_write", {31'b0, rf_write}, 0);
        end else begin
            e0 = 0;
            e1 = 0;
            if (run > 0 && p1_if.req && lock1)
                e1 = 1;
            else if (!blocked && p1_if.req && denied >= STARVE_LIMIT)
                e1 = 1;
            else if (p0_if.req)
                e0 = 1;
            else if (p1_if.req)
                e1 = 1;

            srs = e1 ? p1_if.rs    : p0_if.rs;
            srt = e1 ? p1_if.rt    : p0_if.rt;
            srd = e1 ? p1_if.rd    : p0_if.rd;
            swd = e1 ? p1_if.wdata : p0_if.wdata;
            ew  = (e0 && p0_if.we) || (e1 && p1_if.we);

            check("gnt0", {31'b0, p0_if.gnt}, {31'b0, e0});
            check("gnt1", {31'b0, p1_if.gnt}, {31'b0, e1});
            check("rf_write", {31'b0, rf_write}, {31'b0, ew});
            check("rf_rs", {26'b0, rf_rs}, {26'b0, srs});
            check("rf_rt", {26'b0, rf_rt}, {26'b0, srt});
            check("rf_rd", {26'b0, rf_rd}, {26'b0, srd});
            check("rf_wdata", rf_wdata, swd);
            check("rvalid0", {31'b0, p0_if.rvalid}, {31'b0, pv0});
            check("rvalid1", {31'b0, p1_if.rvalid}, {31'b0, pv1});
            if (pv0 || pv1) begin
                check("rsdata", p0_if.rsdata, prs);
                check("rtdata", p1_if.rtdata, prt);
            end

            prs = arch[srs];
            prt = arch[srt];
            if (ew)
                arch[srd] = swd;
            pv0 = e0;
            pv1 = e1;

            if (e1)
                denied = 0;
            else if (p1_if.req)
                denied = (denied < STARVE_LIMIT) ? denied + 1 : denied;
            else
                denied = 0;

            nb = 0;
            if (e1 && lock1 && (run > 0 || !blocked)) begin
                run++;
                if (run == LOCK_MAX) begin
                    run = 0;
                    nb  = 1;
                end
            end else begin
                run = 0;
            end
            blocked = nb;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        p0_if.req = 0; p0_if.we = 0;
        p1_if.req = 0; p1_if.we = 0;
        lock1 = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]  = DW'(i);
            arch[i] = DW'(i);
        end
        reset_n = 0;
        lock1 = 0;
        p0_if.req = 0; p0_if.we = 0; p0_if.rs = 0; p0_if.rt = 0; p0_if.rd = 0; p0_if.wdata = 0;
        p1_if.req = 0; p1_if.we = 0; p1_if.rs = 0; p1_if.rt = 0; p1_if.rd = 0; p1_if.wdata = 0;
        #1;
        check("lit_reset_rvalid0", {31'b0, p0_if.rvalid}, 0);
        check("lit_reset_rvalid1", {31'b0, p1_if.rvalid}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1;

        // Write 0x55 to r5, then read it back.
        p0_if.req = 1; p0_if.we = 1; p0_if.rd = 5; p0_if.wdata = 32'h55;
        #2;
        check("lit_t1_gnt0", {31'b0, p0_if.gnt}, 1);
        check("lit_t1_rf_write", {31'b0, rf_write}, 1);
        check("lit_t1_rf_rd", {26'b0, rf_rd}, 5);
        tick();
        p0_if.we = 0; p0_if.rs = 5; p0_if.rd = 0;
        #2;
        check("lit_t1_gnt0_rd", {31'b0, p0_if.gnt}, 1);
        tick();
        idle();
        #2;
        check("lit_t1_rvalid0", {31'b0, p0_if.rvalid}, 1);
        check("lit_t1_rsdata", p0_if.rsdata, 32'h55);
        tick();

        // Both requesting: port 1 wins every fifth cycle.
        p0_if.req = 1; p0_if.rs = 1; p0_if.rt = 2;
        p1_if.req = 1; p1_if.rs = 3; p1_if.rt = 4;
        for (int c = 0; c < 15; c++) begin
            #2;
            check("lit_t2_gnt1", {31'b0, p1_if.gnt}, (c % 5 == 4) ? 1 : 0);
            check("lit_t2_gnt0", {31'b0, p0_if.gnt}, (c % 5 == 4) ? 0 : 1);
            tick();
        end
        idle();
        tick();

        // Locked port 1 against a busy port 0: 4 x gnt0, 8 x gnt1 lock,
        // 4 x gnt0 (first one with lock entry refused), then gnt1 again.
        p0_if.req = 1; p0_if.rs = 7;
        p1_if.req = 1; p1_if.we = 1; p1_if.rd = 10; p1_if.rs = 10; p1_if.wdata = 32'h1234;
        lock1 = 1;
        for (int c = 0; c < 17; c++) begin
            #2;
            check("lit_t3_gnt1", {31'b0, p1_if.gnt}, ((c >= 4 && c <= 11) || c == 16) ? 1 : 0);
            tick();
        end
        idle();
        tick();
        tick();

        // Lock release hands the port to port 0 in the same cycle.
        p1_if.req = 1; p1_if.we = 0; lock1 = 1;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("lit_t4_gnt1", {31'b0, p1_if.gnt}, 1);
            tick();
        end
        p0_if.req = 1; lock1 = 0;
        #2;
        check("lit_t4_gnt0", {31'b0, p0_if.gnt}, 1);
        check("lit_t4_gnt1_low", {31'b0, p1_if.gnt}, 0);
        tick();
        idle();
        tick();

        // Same-transaction write and read of r6 returns the old value.
        p0_if.req = 1; p0_if.we = 1; p0_if.rd = 6; p0_if.rs = 6; p0_if.wdata = 32'hAA;
        #2;
        check("lit_t5_gnt0", {31'b0, p0_if.gnt}, 1);
        tick();
        p0_if.we = 0;
        #2;
        check("lit_t5_rvalid0", {31'b0, p0_if.rvalid}, 1);
        check("lit_t5_old", p0_if.rsdata, 32'h6);
        tick();
        idle();
        #2;
        check("lit_t5_new", p0_if.rsdata, 32'hAA);
        tick();
        tick();

        // Reset in the middle of a lock with a read outstanding.
        p1_if.req = 1; p1_if.we = 1; p1_if.rd = 12; p1_if.wdata = 32'hBEEF; lock1 = 1;
        tick();
        #2;
        reset_n = 0;
        #1;
        check("lit_t6_gnt0", {31'b0, p0_if.gnt}, 0);
        check("lit_t6_gnt1", {31'b0, p1_if.gnt}, 0);
        check("lit_t6_rf_write", {31'b0, rf_write}, 0);
        check("lit_t6_rvalid0", {31'b0, p0_if.rvalid}, 0);
        check("lit_t6_rvalid1", {31'b0, p1_if.rvalid}, 0);
        p0_if.req = 1; p0_if.rs = 12;
        tick();
        reset_n = 1;
        #2;
        check("lit_t6_gnt0_after", {31'b0, p0_if.gnt}, 1);
        check("lit_t6_gnt1_after", {31'b0, p1_if.gnt}, 0);
        tick();
        idle();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
